// File: rtl/pc_sequencer.sv
// Program counter / next-PC unit with relative branches, ring return stack, stall and soft restart.
// Optional PC_STACK_FAULT_EN: sticky fault on stack overflow/underflow, freezing the PC until op 111.
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                OFFSET_W     = 8,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [2:0]                       pc_op,
  input  logic                             cond,
  input  logic [OFFSET_W-1:0]              offset,
  input  logic [ADDR_W-1:0]                target,
  output logic [ADDR_W-1:0]                pc_out,
  output logic [ADDR_W-1:0]                pc_next,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_full,
  output logic                             stack_empty
`ifdef PC_STACK_FAULT_EN
  ,
  output logic                             fault
`endif
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH+1);
`ifdef PC_STACK_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000, OP_INC = 3'b001, OP_BR  = 3'b010, OP_JMP = 3'b011,
    OP_CALL = 3'b100, OP_RET = 3'b101, OP_RSV = 3'b110, OP_RST = 3'b111
  } op_e;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_dec;
  logic [ADDR_W-1:0] pc_inc, br_tgt, pc_nxt;
  logic signed [ADDR_W-1:0] off_ext;
  logic              push, pop, clr, flt, flt_set;
  op_e               op;

  assign op          = op_e'(pc_op);
  assign sp_dec      = sp - SP_W'(1);
  assign pc_inc      = pc_out + ADDR_W'(1);
  assign off_ext     = ADDR_W'($signed(offset));
  assign br_tgt      = pc_out + off_ext;
  assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);
  assign pc_next     = pc_nxt;
`ifdef PC_STACK_FAULT_EN
  assign fault       = flt;
`endif

  // Restart always wins; a latched fault blocks every other op.
  always_comb begin
    pc_nxt  = pc_out;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    flt_set = 1'b0;
    if (op == OP_RST) begin
      pc_nxt = RESET_VECTOR;
      clr    = 1'b1;
    end else if (!flt) begin
      case (op)
        OP_INC: pc_nxt = pc_inc;
        OP_BR:  pc_nxt = cond ? br_tgt : pc_inc;
        OP_JMP: pc_nxt = target;
        OP_CALL: begin
          if (FAULT_EN && stack_full) flt_set = 1'b1;
          else begin
            push   = 1'b1;
            pc_nxt = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            if (FAULT_EN) flt_set = 1'b1;
            else          pc_nxt  = pc_inc;
          end else begin
            pop    = 1'b1;
            pc_nxt = stack[sp_dec];
          end
        end
        default: pc_nxt = pc_out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out      <= RESET_VECTOR;
      sp          <= '0;
      stack_count <= '0;
      flt         <= 1'b0;
    end else if (en) begin
      pc_out <= pc_nxt;
      if (clr) begin
        sp          <= '0;
        stack_count <= '0;
        flt         <= 1'b0;
      end else if (push) begin
        sp <= sp + SP_W'(1);
        if (!stack_full) stack_count <= stack_count + CNT_W'(1);
      end else if (pop) begin
        sp          <= sp_dec;
        stack_count <= stack_count - CNT_W'(1);
      end
      if (flt_set) flt <= 1'b1;
    end
  end

  // Entries need no reset; a full ring simply overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (!reset && en && push) stack[sp] <= pc_inc;
  end

endmodule
